gain_code_driver: RTL and testbench
===================================

Name: gain_code_driver

Overview:
- Sequential encoder that drives the front-end DC-compensation code (DC_Comp, 7 positions) and PGA gain code (PGA_Gain, 4 positions) from target positions.
- It is the writer side of the position-decode interface: it produces one-hot codes whose lowest set bit equals the position.
- It walks each code one position per step, holding each step for a settle interval, so the analog chain never sees multi-position jumps.
- It sits between the AGC/DC-tracking control logic and the analog front-end control pins.

Parameters:
- SETTLE_CYCLES, 4, hold cycles after each single-position step; legal range 1..255.
- DC_RST_POS, 0, DC position applied at reset; legal range 0..6.
- PGA_RST_POS, 0, PGA position applied at reset; legal range 0..3.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- load_valid  input  1  target request valid.
- load_ready  output  1  block idle and able to accept a target.
- dc_tgt  input  3  target DC position (0..6).
- pga_tgt  input  2  target PGA position (0..3).
- DC_Comp  output  7  DC-compensation code.
- PGA_Gain  output  4  PGA gain code, one-hot.
- dc_pos  output  3  current DC position.
- pga_pos  output  3  current PGA position (upper bit always 0).
- busy  output  1  walk in progress.
- done  output  1  one-cycle pulse when the walk completes.
- tgt_err  output  1  one-cycle pulse on acceptance of an out-of-range dc_tgt.

Behaviour:
- Reset (asynchronous, immediate, also mid-walk):
  - dc_pos=DC_RST_POS, pga_pos=PGA_RST_POS; DC_Comp and PGA_Gain are the matching codes.
  - load_ready=1, busy=0, done=0, tgt_err=0; state IDLE; settle counter 0.
- Encoding:
  - DC_Comp = 1 << dc_pos.
  - PGA_Gain = 1 << pga_pos.
  - Exactly one bit is set at all times; both codes are registered outputs with no glitches.
- Handshake:
  - A target is accepted on the rising edge where load_valid && load_ready.
  - dc_tgt and pga_tgt are captured on that edge.
  - load_ready=0 from the next cycle until the cycle after done; load_valid is ignored while load_ready=0.
- Clamp:
  - Captured dc_tgt of 7 is clamped to 6, and tgt_err pulses in the cycle after acceptance.
  - pga_tgt is always legal.
- FSM states: IDLE, STEP_DC, SETTLE_DC, STEP_PGA, SETTLE_PGA, DONE.
  - IDLE: on accept, go to STEP_DC; busy=1 from the next cycle.
  - STEP_DC: if dc_pos != target, move dc_pos one position toward the target (+1 or -1), load the counter with SETTLE_CYCLES-1, and go to SETTLE_DC. Otherwise go to STEP_PGA.
  - SETTLE_DC: decrement the counter; at 0, go to STEP_DC.
  - STEP_PGA and SETTLE_PGA: identical to the DC pair, acting on pga_pos.
  - DONE: done=1 and busy=0 for this cycle, then go to IDLE. load_ready=1 the following cycle.
- Ordering: the DC walk always completes before the PGA walk starts.
- Timing (edges counted from the acceptance edge E0, S = SETTLE_CYCLES):
  - The k-th DC step appears at edge (k-1)(S+1)+1.
  - done is high in the cycle after edge (Ndc+Npga)(S+1)+2.
  - A zero-step load (targets equal current positions) gives done after edge 2, with no output change.
- Simultaneous load_valid with reset: reset wins and nothing is captured.

Optional Feature:
- Macro: DC_THERMO_CODE_EN.
- Defined:
  - DC_Comp is a thermometer code with bits [6:dc_pos] set and bits below dc_pos cleared. The lowest set bit still equals dc_pos.
  - Reset value with DC_RST_POS=0 is 7'b1111111.
  - Stepping rules and timing are unchanged.
- Undefined: DC_Comp is one-hot, as above.
- PGA_Gain is always one-hot, with or without the macro.

Test Plan:
- Reset release with defaults -> DC_Comp=7'b0000001, PGA_Gain=4'b0001, load_ready=1, busy=0.
- S=4; load dc_tgt=3, pga_tgt=2 from 0/0:
  - DC_Comp goes 0000010, 0000100, 0001000 at edges 1, 6, 11.
  - PGA_Gain goes 0010, 0100 at edges 17, 22.
  - done is high after edge 27; load_ready returns the following cycle.
- From dc_pos=5, load dc_tgt=1, pga_tgt=unchanged:
  - DC_Comp steps down one position per 5 cycles to 7'b0000010.
  - PGA_Gain does not change; done after edge 22.
- load_valid held high during a walk with different targets -> ignored; the original walk completes unchanged.
- Load dc_tgt=7 -> tgt_err pulses once; walk ends at DC_Comp=7'b1000000.
- rst_n asserted mid-settle -> outputs return to reset codes immediately.
- With DC_THERMO_CODE_EN defined, load dc_tgt=2 -> DC_Comp=7'b1111100 at the final step.

Source files
------------

// File: rtl/gain_code_driver.sv
// Walks the DC-compensation and PGA gain codes toward target positions, one position per step, with a settle hold after each step.
// Optional macro DC_THERMO_CODE_EN switches DC_Comp from one-hot to a thermometer code with bits [6:dc_pos] set.
module gain_code_driver #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned DC_RST_POS    = 0,
  parameter int unsigned PGA_RST_POS   = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_valid,
  output logic       load_ready,
  input  logic [2:0] dc_tgt,
  input  logic [1:0] pga_tgt,
  output logic [6:0] DC_Comp,
  output logic [3:0] PGA_Gain,
  output logic [2:0] dc_pos,
  output logic [2:0] pga_pos,
  output logic       busy,
  output logic       done,
  output logic       tgt_err
);

  typedef enum logic [2:0] {
    IDLE,
    STEP_DC,
    SETTLE_DC,
    STEP_PGA,
    SETTLE_PGA,
    DONE
  } state_e;

  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);
  localparam logic [2:0] DC_RST      = 3'(DC_RST_POS);
  localparam logic [1:0] PGA_RST     = 2'(PGA_RST_POS);
  localparam logic [2:0] DC_MAX      = 3'd6;

  function automatic logic [6:0] dc_code(input logic [2:0] pos);
`ifdef DC_THERMO_CODE_EN
    return 7'h7f << pos;
`else
    return 7'h01 << pos;
`endif
  endfunction

  function automatic logic [3:0] pga_code(input logic [1:0] pos);
    return 4'h1 << pos;
  endfunction

  state_e     state_q, state_d;
  logic [2:0] dc_pos_q, dc_pos_d;
  logic [1:0] pga_pos_q, pga_pos_d;
  logic [2:0] dc_tgt_q, dc_tgt_d;
  logic [1:0] pga_tgt_q, pga_tgt_d;
  logic [7:0] cnt_q, cnt_d;
  logic       tgt_err_q, tgt_err_d;
  logic [6:0] dc_code_q;
  logic [3:0] pga_code_q;
  logic       ready_q, busy_q, done_q;
  logic       accept;

  assign accept = load_valid && (state_q == IDLE);

  // NOTE: every variable gets a default before the case so no path leaves it unassigned, which would infer a latch.
  always_comb begin
    state_d   = state_q;
    dc_pos_d  = dc_pos_q;
    pga_pos_d = pga_pos_q;
    dc_tgt_d  = dc_tgt_q;
    pga_tgt_d = pga_tgt_q;
    cnt_d     = cnt_q;
    tgt_err_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d   = STEP_DC;
          dc_tgt_d  = (dc_tgt > DC_MAX) ? DC_MAX : dc_tgt;
          pga_tgt_d = pga_tgt;
          tgt_err_d = (dc_tgt > DC_MAX);
        end
      end
      STEP_DC: begin
        if (dc_pos_q != dc_tgt_q) begin
          dc_pos_d = (dc_pos_q < dc_tgt_q) ? dc_pos_q + 3'd1 : dc_pos_q - 3'd1;
          cnt_d    = SETTLE_LOAD;
          state_d  = SETTLE_DC;
        end else begin
          state_d = STEP_PGA;
        end
      end
      SETTLE_DC: begin
        if (cnt_q == 8'd0) state_d = STEP_DC;
        else               cnt_d   = cnt_q - 8'd1;
      end
      STEP_PGA: begin
        if (pga_pos_q != pga_tgt_q) begin
          pga_pos_d = (pga_pos_q < pga_tgt_q) ? pga_pos_q + 2'd1 : pga_pos_q - 2'd1;
          cnt_d     = SETTLE_LOAD;
          state_d   = SETTLE_PGA;
        end else begin
          state_d = DONE;
        end
      end
      SETTLE_PGA: begin
        if (cnt_q == 8'd0) state_d = STEP_PGA;
        else               cnt_d   = cnt_q - 8'd1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      dc_pos_q   <= DC_RST;
      pga_pos_q  <= PGA_RST;
      dc_tgt_q   <= DC_RST;
      pga_tgt_q  <= PGA_RST;
      cnt_q      <= 8'd0;
      tgt_err_q  <= 1'b0;
      dc_code_q  <= dc_code(DC_RST);
      pga_code_q <= pga_code(PGA_RST);
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      dc_pos_q   <= dc_pos_d;
      pga_pos_q  <= pga_pos_d;
      dc_tgt_q   <= dc_tgt_d;
      pga_tgt_q  <= pga_tgt_d;
      cnt_q      <= cnt_d;
      tgt_err_q  <= tgt_err_d;
      // Codes are flopped from next-state positions so the pins change only on clock edges.
      dc_code_q  <= dc_code(dc_pos_d);
      pga_code_q <= pga_code(pga_pos_d);
      ready_q    <= (state_d == IDLE);
      busy_q     <= (state_d != IDLE) && (state_d != DONE);
      done_q     <= (state_d == DONE);
    end
  end

  assign load_ready = ready_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign tgt_err    = tgt_err_q;
  assign DC_Comp    = dc_code_q;
  assign PGA_Gain   = pga_code_q;
  assign dc_pos     = dc_pos_q;
  assign pga_pos    = {1'b0, pga_pos_q};

endmodule

// File: tb/tb_gain_code_driver.sv
// Randomized self-checking bench for gain_code_driver; expected outputs come from closed-form step timing per walk.
module tb_gain_code_driver;

  localparam int S = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load_valid = 1'b0;
  logic [2:0] dc_tgt = 3'd0;
  logic [1:0] pga_tgt = 2'd0;
  logic       load_ready, busy, done, tgt_err;
  logic [6:0] DC_Comp;
  logic [3:0] PGA_Gain;
  logic [2:0] dc_pos, pga_pos;

  int pass_cnt = 0;
  int total_cnt = 0;
  int model_dc = 0;
  int model_pga = 0;

  gain_code_driver #(
    .SETTLE_CYCLES(S),
    .DC_RST_POS   (0),
    .PGA_RST_POS  (0)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .dc_tgt    (dc_tgt),
    .pga_tgt   (pga_tgt),
    .DC_Comp   (DC_Comp),
    .PGA_Gain  (PGA_Gain),
    .dc_pos    (dc_pos),
    .pga_pos   (pga_pos),
    .busy      (busy),
    .done      (done),
    .tgt_err   (tgt_err)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [6:0] exp_dc_code(input int pos);
    logic [6:0] c;
    for (int i = 0; i < 7; i++) begin
`ifdef DC_THERMO_CODE_EN
      c[i] = (i >= pos);
`else
      c[i] = (i == pos);
`endif
    end
    return c;
  endfunction

  function automatic logic [3:0] exp_pga_code(input int pos);
    logic [3:0] c;
    for (int i = 0; i < 4; i++) c[i] = (i == pos);
    return c;
  endfunction

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Applies one target, then compares every cycle from the acceptance edge until load_ready returns.
  task automatic do_walk(input int dct, input int pgat, input bit hold_valid);
    int eff_dc, ndc, npga, dir_dc, dir_pga, d_edge, k_dc, k_pga, jp;
    int e_dcpos, e_pgapos;
    eff_dc  = (dct > 6) ? 6 : dct;
    ndc     = (eff_dc > model_dc) ? eff_dc - model_dc : model_dc - eff_dc;
    npga    = (pgat > model_pga) ? pgat - model_pga : model_pga - pgat;
    dir_dc  = (eff_dc >= model_dc) ? 1 : -1;
    dir_pga = (pgat >= model_pga) ? 1 : -1;
    d_edge  = (ndc + npga) * (S + 1) + 2;

    total_cnt++;
    if (load_ready !== 1'b1) $display("FAIL ready_before_load got %b exp 1", load_ready);
    else pass_cnt++;

    load_valid = 1'b1;
    dc_tgt     = 3'(dct);
    pga_tgt    = 2'(pgat);
    @(posedge clk);
    for (int t = 0; t <= d_edge + 1; t++) begin
      @(negedge clk);
      if (t == 0) begin
        if (hold_valid) begin
          dc_tgt  = 3'($urandom_range(0, 7));
          pga_tgt = 2'($urandom_range(0, 3));
        end else begin
          load_valid = 1'b0;
        end
      end
      if (t >= d_edge) load_valid = 1'b0;
      k_dc     = (t >= 1) ? imin(ndc, (t - 1) / (S + 1) + 1) : 0;
      jp       = t - 2 - ndc * (S + 1);
      k_pga    = (jp >= 0) ? imin(npga, jp / (S + 1) + 1) : 0;
      e_dcpos  = model_dc + dir_dc * k_dc;
      e_pgapos = model_pga + dir_pga * k_pga;

      total_cnt++;
      if (DC_Comp !== exp_dc_code(e_dcpos))
        $display("FAIL dc_comp t=%0d got %b exp %b", t, DC_Comp, exp_dc_code(e_dcpos));
      else pass_cnt++;
      total_cnt++;
      if (PGA_Gain !== exp_pga_code(e_pgapos))
        $display("FAIL pga_gain t=%0d got %b exp %b", t, PGA_Gain, exp_pga_code(e_pgapos));
      else pass_cnt++;
      total_cnt++;
      if (dc_pos !== 3'(e_dcpos)) $display("FAIL dc_pos t=%0d got %0d exp %0d", t, dc_pos, e_dcpos);
      else pass_cnt++;
      total_cnt++;
      if (pga_pos !== 3'(e_pgapos)) $display("FAIL pga_pos t=%0d got %0d exp %0d", t, pga_pos, e_pgapos);
      else pass_cnt++;
      total_cnt++;
      if (busy !== (t < d_edge)) $display("FAIL busy t=%0d got %b exp %b", t, busy, (t < d_edge));
      else pass_cnt++;
      total_cnt++;
      if (done !== (t == d_edge)) $display("FAIL done t=%0d got %b exp %b", t, done, (t == d_edge));
      else pass_cnt++;
      total_cnt++;
      if (load_ready !== (t > d_edge))
        $display("FAIL load_ready t=%0d got %b exp %b", t, load_ready, (t > d_edge));
      else pass_cnt++;
      total_cnt++;
      if (tgt_err !== (t == 0 && dct == 7))
        $display("FAIL tgt_err t=%0d got %b exp %b", t, tgt_err, (t == 0 && dct == 7));
      else pass_cnt++;
    end
    model_dc  = eff_dc;
    model_pga = pgat;
  endtask

  task automatic test_reset;
    load_valid = 1'b1;
    dc_tgt     = 3'd5;
    pga_tgt    = 2'd3;
    rst_n      = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total_cnt++;
    if (DC_Comp !== exp_dc_code(0)) $display("FAIL reset_dc_comp got %b exp %b", DC_Comp, exp_dc_code(0));
    else pass_cnt++;
    total_cnt++;
    if (PGA_Gain !== 4'b0001) $display("FAIL reset_pga_gain got %b exp 0001", PGA_Gain);
    else pass_cnt++;
    total_cnt++;
    if ({load_ready, busy, done, tgt_err} !== 4'b1000)
      $display("FAIL reset_flags got %b exp 1000", {load_ready, busy, done, tgt_err});
    else pass_cnt++;
    load_valid = 1'b0;
    rst_n      = 1'b1;
    @(negedge clk);
    total_cnt++;
    if ({load_ready, busy, dc_pos, pga_pos} !== {1'b1, 1'b0, 3'd0, 3'd0})
      $display("FAIL reset_release got rdy=%b busy=%b dc=%0d pga=%0d exp 1 0 0 0",
               load_ready, busy, dc_pos, pga_pos);
    else pass_cnt++;
    model_dc  = 0;
    model_pga = 0;
  endtask

  task automatic test_spec_walk;
    do_walk(3, 2, 1'b0);
  endtask

  task automatic test_walk_down;
    do_walk(5, model_pga, 1'b0);
    do_walk(1, model_pga, 1'b0);
  endtask

  task automatic test_zero_step;
    do_walk(model_dc, model_pga, 1'b0);
  endtask

  task automatic test_hold_valid;
    do_walk(4, 1, 1'b1);
    do_walk(0, 3, 1'b1);
  endtask

  task automatic test_clamp;
    do_walk(7, 0, 1'b0);
    total_cnt++;
    if (DC_Comp !== exp_dc_code(6)) $display("FAIL clamp_final got %b exp %b", DC_Comp, exp_dc_code(6));
    else pass_cnt++;
  endtask

  task automatic test_random;
    for (int n = 0; n < 24; n++)
      do_walk(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
  endtask

  task automatic test_reset_mid_walk;
    do_walk(6, 3, 1'b0);
    load_valid = 1'b1;
    dc_tgt     = 3'd0;
    pga_tgt    = 2'd0;
    @(posedge clk);
    repeat (3) @(negedge clk);
    load_valid = 1'b0;
    total_cnt++;
    if (dc_pos !== 3'd5) $display("FAIL mid_walk_pos got %0d exp 5", dc_pos);
    else pass_cnt++;
    #2 rst_n = 1'b0;
    #1;
    total_cnt++;
    if (DC_Comp !== exp_dc_code(0)) $display("FAIL async_reset_dc got %b exp %b", DC_Comp, exp_dc_code(0));
    else pass_cnt++;
    total_cnt++;
    if (PGA_Gain !== 4'b0001) $display("FAIL async_reset_pga got %b exp 0001", PGA_Gain);
    else pass_cnt++;
    total_cnt++;
    if ({load_ready, busy, done} !== 3'b100)
      $display("FAIL async_reset_flags got %b exp 100", {load_ready, busy, done});
    else pass_cnt++;
    @(negedge clk);
    rst_n     = 1'b1;
    model_dc  = 0;
    model_pga = 0;
    @(negedge clk);
    do_walk(2, 1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_spec_walk();
    test_walk_down();
    test_zero_step();
    test_hold_valid();
    test_clamp();
    test_random();
    test_reset_mid_walk();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
